packet_seq_ctrl: RTL and testbench

PACKET_SEQ_CTRL -- requirements
Module: packet_seq_ctrl

---
 rtl/packet_seq_ctrl_pkg.sv | 27 ++
 rtl/packet_seq_ctrl_if.sv | 34 +++
 rtl/packet_seq_ctrl_pkt_len_calc.sv | 12 +
 rtl/packet_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_packet_seq_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/packet_seq_ctrl_pkg.sv
// Shared types and constants for the telemetry packet sequencer.
package packet_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    HDR0    = 3'd0,
    HDR1    = 3'd1,
    PAYLOAD = 3'd2,
    FLUSH   = 3'd3,
    DROP    = 3'd4
  } state_t;

  localparam logic [15:0] DEF_MAX_LEN   = 16'd4095;
  localparam logic [10:0] DEF_IDLE_APID = 11'h7FF;

  // Bit positions within the 48-bit primary header.
  localparam int HDR_APID_MSB = 42;
  localparam int HDR_APID_LSB = 32;
  localparam int HDR_SEQ_MSB  = 29;
  localparam int HDR_SEQ_LSB  = 16;
  localparam int HDR_LEN_MSB  = 15;
  localparam int HDR_LEN_LSB  = 0;

  // word0 carries hdr[47:16]; word1[31:16] carries hdr[15:0].
  localparam int W0_OFS = 16;
  localparam int W1_OFS = 16;

endpackage

// File: rtl/packet_seq_ctrl_if.sv
// Stream input, datapath output and header-field bundle of the sequencer.
interface packet_seq_ctrl_if;
  import packet_seq_ctrl_pkg::*;

  // A word transfers on a rising edge where in_valid && in_ready; in_valid
  // may drop at any time and in_data is only meaningful while in_valid is high.
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dp_data;
  logic        dp_shift;
  logic        dp_datavalid;
  logic [10:0] pkt_apid;
  logic [13:0] pkt_seq;
  logic [15:0] pkt_len;
  logic        hdr_valid;
  logic        pkt_last;
  logic        err_len;
  logic [15:0] idle_cnt;
  state_t      dbg_state;

  modport master (
    output in_data, in_valid,
    input  in_ready, dp_data, dp_shift, dp_datavalid, pkt_apid, pkt_seq,
           pkt_len, hdr_valid, pkt_last, err_len, idle_cnt, dbg_state
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, dp_data, dp_shift, dp_datavalid, pkt_apid, pkt_seq,
           pkt_len, hdr_valid, pkt_last, err_len, idle_cnt, dbg_state
  );

endinterface

// File: rtl/packet_seq_ctrl_pkt_len_calc.sv
// Input-word count N and payload-word count P from the length field L.
module pkt_len_calc (
  input  logic [15:0] len,
  output logic [15:0] n_words,
  output logic [15:0] p_words
);

  // N = ceil((L+7)/4), P = ceil((L+1)/4); 17-bit sums avoid wrap at L=FFFF.
  assign n_words = 16'((17'(len) + 17'd10) >> 2);
  assign p_words = 16'((17'(len) + 17'd4) >> 2);

endmodule

// File: rtl/packet_seq_ctrl.sv
// Packet sequencer: splits telemetry words into header fields and payload
// shifts, drops idle/oversized packets, and pads short payloads with a flush.
module packet_seq_ctrl
  import packet_seq_ctrl_pkg::*;
#(
  parameter logic [15:0] MAX_LEN   = DEF_MAX_LEN,
  parameter logic [10:0] IDLE_APID = DEF_IDLE_APID
) (
  input logic              clk,
  input logic              reset,
  packet_seq_ctrl_if.slave bus
);

  state_t      state_q, state_d;
  logic        rdy_q;
  logic        acc;
  logic [15:0] idx_q, idx_d;
  logic [15:0] emit_q, emit_d;
  logic [15:0] calc_len, n_words, p_words;

  logic [31:0] dp_data_q, dp_data_d;
  logic        dp_shift_q, dp_shift_d;
  logic        dp_dv_q, dp_dv_d;
  logic        last_q, last_d;

  logic [10:0] pend_apid_q;
  logic [13:0] pend_seq_q;
  logic [10:0] apid_q;
  logic [13:0] seq_q;
  logic [15:0] len_q;
  logic        hdr_valid_q, err_q;
  logic [15:0] idle_q;
  logic        hdr_load, is_idle, is_err;

  // rdy_q keeps in_ready low while reset is held and for the release cycle.
  assign bus.in_ready = rdy_q && (state_q != FLUSH);
  assign acc          = bus.in_valid && bus.in_ready;
  assign calc_len     = (state_q == HDR1) ? bus.in_data[31:16] : len_q;

  pkt_len_calc u_len_calc (
    .len     (calc_len),
    .n_words (n_words),
    .p_words (p_words)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HDR0;
      rdy_q   <= 1'b0;
      idx_q   <= '0;
      emit_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      idx_q   <= idx_d;
      emit_q  <= emit_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    emit_d     = emit_q;
    dp_data_d  = dp_data_q;
    dp_shift_d = 1'b0;
    dp_dv_d    = 1'b0;
    last_d     = 1'b0;
    hdr_load   = 1'b0;
    is_idle    = 1'b0;
    is_err     = 1'b0;
    case (state_q)
      HDR0: begin
        if (acc) begin
          dp_shift_d = 1'b1;
          dp_data_d  = bus.in_data;
          idx_d      = 16'd1;
          state_d    = HDR1;
        end
      end
      HDR1: begin
        if (acc) begin
          dp_shift_d = 1'b1;
          dp_data_d  = bus.in_data;
          hdr_load   = 1'b1;
          is_idle    = (pend_apid_q == IDLE_APID);
          is_err     = (bus.in_data[31:16] > MAX_LEN);
          idx_d      = 16'd2;
          emit_d     = '0;
          // A two-word packet has no payload input words left to accept.
          if (is_idle || is_err)
            state_d = (n_words <= 16'd2) ? HDR0 : DROP;
          else
            state_d = (n_words <= 16'd2) ? FLUSH : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (acc) begin
          dp_shift_d = 1'b1;
          dp_data_d  = bus.in_data;
          idx_d      = idx_q + 16'd1;
          if (emit_q < p_words) begin
            dp_dv_d = 1'b1;
            emit_d  = emit_q + 16'd1;
            last_d  = ((emit_q + 16'd1) == p_words);
          end
          if (idx_q == n_words - 16'd1)
            state_d = (emit_d < p_words) ? FLUSH : HDR0;
        end
      end
      FLUSH: begin
        dp_data_d  = '0;
        dp_shift_d = 1'b1;
        dp_dv_d    = 1'b1;
        last_d     = 1'b1;
        state_d    = HDR0;
      end
      DROP: begin
        if (acc) begin
          idx_d = idx_q + 16'd1;
          if (idx_q == n_words - 16'd1)
            state_d = HDR0;
        end
      end
      default: state_d = HDR0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dp_data_q  <= '0;
      dp_shift_q <= 1'b0;
      dp_dv_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      dp_data_q  <= dp_data_d;
      dp_shift_q <= dp_shift_d;
      dp_dv_q    <= dp_dv_d;
      last_q     <= last_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_apid_q <= '0;
      pend_seq_q  <= '0;
      apid_q      <= '0;
      seq_q       <= '0;
      len_q       <= '0;
      hdr_valid_q <= 1'b0;
      err_q       <= 1'b0;
      idle_q      <= '0;
    end else begin
      hdr_valid_q <= hdr_load;
      err_q       <= hdr_load && is_err;
      if (state_q == HDR0 && acc) begin
        pend_apid_q <= bus.in_data[HDR_APID_MSB-W0_OFS:HDR_APID_LSB-W0_OFS];
        pend_seq_q  <= bus.in_data[HDR_SEQ_MSB-W0_OFS:HDR_SEQ_LSB-W0_OFS];
      end
      if (hdr_load) begin
        apid_q <= pend_apid_q;
        seq_q  <= pend_seq_q;
        len_q  <= bus.in_data[HDR_LEN_MSB+W1_OFS:HDR_LEN_LSB+W1_OFS];
        if (is_idle && idle_q != 16'hFFFF)
          idle_q <= idle_q + 16'd1;
      end
    end
  end

  assign bus.dp_data      = dp_data_q;
  assign bus.dp_shift     = dp_shift_q;
  assign bus.dp_datavalid = dp_dv_q;
  assign bus.pkt_last     = last_q;
  assign bus.pkt_apid     = apid_q;
  assign bus.pkt_seq      = seq_q;
  assign bus.pkt_len      = len_q;
  assign bus.hdr_valid    = hdr_valid_q;
  assign bus.err_len      = err_q;
  assign bus.idle_cnt     = idle_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_packet_seq_ctrl.sv
// Randomized scoreboard bench for packet_seq_ctrl against a packet-level model.
module tb_packet_seq_ctrl;
  import packet_seq_ctrl_pkg::*;

  localparam logic [15:0] TB_MAX_LEN = 16'd4095;
  localparam logic [10:0] TB_IDLE    = 11'h7FF;

  logic clk = 1'b0;
  logic reset = 1'b0;

  packet_seq_ctrl_if bus();

  packet_seq_ctrl #(.MAX_LEN(TB_MAX_LEN), .IDLE_APID(TB_IDLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int idle_model = 0;
  bit gaps_on = 1'b1;

  logic [33:0] exp_q[$];   // {dp_data, dp_datavalid, pkt_last}
  logic [57:0] hdr_q[$];   // {apid, seq, len, err_len, idle_cnt}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic send_word(input logic [31:0] w);
    bit ok;
    if (gaps_on && $urandom_range(0, 3) == 0) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    bus.in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  // Sends up to n_send words of a packet, pushing the expected outputs first.
  task automatic send_packet(input logic [10:0] apid, input logic [13:0] seq,
                             input logic [15:0] len, input int n_send);
    int n, p;
    bit idle, err, drop, flush;
    logic [31:0] w;
    n = (int'(len) + 7 + 3) / 4;
    p = (int'(len) + 1 + 3) / 4;
    idle = (apid == TB_IDLE);
    err  = (len > TB_MAX_LEN);
    drop = idle || err;
    flush = !drop && (n - 2 < p);
    for (int k = 0; k < n && k < n_send; k++) begin
      if (k == 0) begin
        w = {5'($urandom), apid, 2'($urandom), seq};
        exp_q.push_back({w, 1'b0, 1'b0});
      end else if (k == 1) begin
        w = {len, 16'($urandom)};
        if (idle && idle_model < 65535) idle_model++;
        hdr_q.push_back({apid, seq, len, err, 16'(idle_model)});
        exp_q.push_back({w, 1'b0, 1'b0});
      end else begin
        w = $urandom;
        if (!drop)
          exp_q.push_back({w, (k - 2) < p, (k - 2) == p - 1});
      end
      if (k == n - 1 && flush)
        exp_q.push_back({32'd0, 1'b1, 1'b1});
      send_word(w);
    end
    if (flush && n_send >= n)
      chk("in_ready_in_flush", 64'(bus.in_ready), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    chk({tag, "_dp"}, {bus.dp_data, bus.dp_shift, bus.dp_datavalid, bus.pkt_last}, 64'd0);
    chk({tag, "_fields"}, {bus.pkt_apid, bus.pkt_seq, bus.pkt_len}, 64'd0);
    chk({tag, "_pulses"}, {bus.hdr_valid, bus.err_len}, 64'd0);
    chk({tag, "_idle_cnt"}, 64'(bus.idle_cnt), 64'd0);
    chk({tag, "_state"}, 64'(bus.dbg_state), 64'(HDR0));
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [33:0] e;
    logic [57:0] h;
    forever begin
      @(posedge clk);
      #1;
      if (bus.dp_shift) begin
        if (exp_q.size() == 0) begin
          chk("dp_unexpected_shift", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("dp_data", 64'(bus.dp_data), 64'(e[33:2]));
          chk("dp_datavalid", 64'(bus.dp_datavalid), 64'(e[1]));
          chk("pkt_last", 64'(bus.pkt_last), 64'(e[0]));
        end
      end else if (bus.dp_datavalid || bus.pkt_last) begin
        chk("dv_without_shift", 64'd1, 64'd0);
      end
      if (bus.hdr_valid) begin
        if (hdr_q.size() == 0) begin
          chk("hdr_unexpected", 64'd1, 64'd0);
        end else begin
          h = hdr_q.pop_front();
          chk("pkt_apid", 64'(bus.pkt_apid), 64'(h[57:47]));
          chk("pkt_seq", 64'(bus.pkt_seq), 64'(h[46:33]));
          chk("pkt_len", 64'(bus.pkt_len), 64'(h[32:17]));
          chk("err_len", 64'(bus.err_len), 64'(h[16]));
          chk("idle_cnt", 64'(bus.idle_cnt), 64'(h[15:0]));
        end
      end else if (bus.err_len) begin
        chk("err_without_hdr", 64'd1, 64'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [10:0] a;
    logic [15:0] l;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_release", 64'(bus.in_ready), 64'd1);

    // Directed boundary packets.
    send_packet(11'd5, 14'd1, 16'd7, 9999);
    send_packet(11'd6, 14'd2, 16'd9, 9999);
    send_packet(11'd7, 14'd3, 16'd0, 9999);
    send_packet(TB_IDLE, 14'd4, 16'd3, 9999);
    send_packet(11'd8, 14'd5, 16'd12, 9999);
    send_packet(11'd9, 14'd6, 16'd5000, 9999);
    send_packet(11'd10, 14'd7, 16'd1, 9999);
    send_packet(TB_IDLE, 14'd8, 16'd0, 9999);

    // Random packets.
    for (int i = 0; i < 30; i++) begin
      a = ($urandom_range(0, 5) == 0) ? TB_IDLE : 11'($urandom_range(0, 2046));
      l = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(4096, 4200))
                                      : 16'($urandom_range(0, 40));
      send_packet(a, 14'($urandom), l, 9999);
    end

    // Reset mid-payload: the partial packet must end without a flush or last.
    send_packet(11'd33, 14'd9, 16'd40, 7);
    @(negedge clk);
    chk("queue_drained_before_reset", 64'(exp_q.size() + hdr_q.size()), 64'd0);
    reset = 1'b0;
    idle_model = 0;
    #1;
    check_reset_outputs("midpkt_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_midpkt", 64'(bus.in_ready), 64'd1);
    chk("state_after_midpkt", 64'(bus.dbg_state), 64'(HDR0));
    send_packet(11'd44, 14'd10, 16'd9, 9999);
    send_packet(TB_IDLE, 14'd11, 16'd2, 9999);
    send_packet(11'd45, 14'd12, 16'd6, 9999);

    repeat (5) @(posedge clk);
    #2;
    chk("final_idle_cnt", 64'(bus.idle_cnt), 64'(idle_model));
    chk("final_dp_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("final_hdr_queue_empty", 64'(hdr_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
